// File: rtl/downstream_rmw_arbiter.sv
// Round-robin arbiter that serialises cancellation feeds onto a single-ported
// per-client RAM, doing one read / saturating add / write per accepted request.
module downstream_rmw_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0]    i_req_client_id,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_amount,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [ID_WIDTH-1:0]            o_ram_addr,
    input  logic [DATA_WIDTH-1:0]          i_ram_read_data,
    output logic [DATA_WIDTH-1:0]          o_ram_write_data,
    output logic                           o_ram_write_enable,
    output logic                           o_upd_valid,
    output logic [ID_WIDTH-1:0]            o_upd_client_id,
    output logic [DATA_WIDTH-1:0]          o_upd_total,
    output logic                           o_upd_saturated,
    output logic                           o_busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_ACC   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_amount;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_sat;

    logic [ID_WIDTH-1:0]   w_ids  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_amts [NUM_REQ];
    logic                  w_grant_found;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [PTR_W:0]        w_cand;
    logic                  w_accept;
    logic [DATA_WIDTH:0]   w_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_ids[gi]  = i_req_client_id[gi*ID_WIDTH +: ID_WIDTH];
            assign w_amts[gi] = i_req_amount[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Search starts one past the last winner and wraps modulo NUM_REQ.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k + 1);
            if (w_cand >= (PTR_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_grant_found && i_req_valid[w_cand[PTR_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand[PTR_W-1:0];
            end
        end
    end

    // No acceptance while reset is held, so nothing transfers into a dropped pipeline.
    assign w_accept = (r_state == S_IDLE) && w_grant_found && !i_rst;
    assign w_sum    = {1'b0, i_ram_read_data} + {1'b0, r_amount};

    always_comb begin
        w_state_next = r_state;
        o_req_ready  = '0;
        o_ram_addr   = r_id;
        case (r_state)
            S_IDLE: begin
                o_ram_addr = '0;
                if (w_accept) begin
                    o_req_ready[w_grant_idx] = 1'b1;
                    o_ram_addr               = w_ids[w_grant_idx];
                    w_state_next             = S_READ;
                end
            end
            S_READ:  w_state_next = S_ACC;
            S_ACC:   w_state_next = S_WRITE;
            S_WRITE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= PTR_W'(NUM_REQ - 1);
            r_id     <= '0;
            r_amount <= '0;
            r_result <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id     <= w_ids[w_grant_idx];
                        r_amount <= w_amts[w_grant_idx];
                        r_rr_ptr <= w_grant_idx;
                    end
                end
                S_ACC: begin
                    r_result <= w_sum[DATA_WIDTH] ? '1 : w_sum[DATA_WIDTH-1:0];
                    r_sat    <= w_sum[DATA_WIDTH];
                end
                default: ;
            endcase
        end
    end

    assign o_ram_write_data   = r_result;
    assign o_ram_write_enable = (r_state == S_WRITE);
    assign o_upd_valid        = (r_state == S_WRITE);
    assign o_upd_client_id    = r_id;
    assign o_upd_total        = r_result;
    assign o_upd_saturated    = r_sat;
    assign o_busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_downstream_rmw_arbiter.sv
// Bench for downstream_rmw_arbiter: a 32x32 RAM with 1-cycle read latency plus
// a per-client totals model and a round-robin winner model.
module tb_downstream_rmw_arbiter;
    localparam int N  = 4;
    localparam int IW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*IW-1:0]   req_client_id;
    logic [N*DW-1:0]   req_amount;
    logic [N-1:0]      req_ready;
    logic [IW-1:0]     ram_addr;
    logic [DW-1:0]     ram_read_data;
    logic [DW-1:0]     ram_write_data;
    logic              ram_write_enable;
    logic              upd_valid;
    logic [IW-1:0]     upd_client_id;
    logic [DW-1:0]     upd_total;
    logic              upd_saturated;
    logic              busy;

    always #5 clk = ~clk;

    downstream_rmw_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req_valid        (req_valid),
        .i_req_client_id    (req_client_id),
        .i_req_amount       (req_amount),
        .o_req_ready        (req_ready),
        .o_ram_addr         (ram_addr),
        .i_ram_read_data    (ram_read_data),
        .o_ram_write_data   (ram_write_data),
        .o_ram_write_enable (ram_write_enable),
        .o_upd_valid        (upd_valid),
        .o_upd_client_id    (upd_client_id),
        .o_upd_total        (upd_total),
        .o_upd_saturated    (upd_saturated),
        .o_busy             (busy)
    );

    // Environment RAM: clear and preload ports keep all writes in one process.
    logic [DW-1:0] ram [32];
    logic          ram_clr;
    logic          pre_en;
    logic [IW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        ram_read_data <= ram[ram_addr];
        if (ram_clr) begin
            for (int i = 0; i < 32; i++) ram[i] <= '0;
        end else begin
            if (ram_write_enable) ram[ram_addr] <= ram_write_data;
            if (pre_en) ram[pre_addr] <= pre_data;
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [32];
    int            last_grant;
    logic [IW-1:0] cur_id  [N];
    logic [DW-1:0] cur_amt [N];

    int n_vec = 0;
    int n_err = 0;

    // Observations of one transaction and their expectations
    logic [N-1:0]  t_rdy;
    int            t_ucyc;
    int            t_wcnt;
    logic [IW-1:0] t_uid;
    logic [DW-1:0] t_utot;
    logic          t_usat;
    logic [IW-1:0] t_waddr;
    logic [DW-1:0] t_wdata;
    logic [N-1:0]  e_rdy;
    logic [IW-1:0] e_id;
    logic [DW-1:0] e_tot;
    logic          e_sat;

    function automatic int rr_winner(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(last_grant + k) % N]) return (last_grant + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [IW-1:0] id, input logic [DW-1:0] amt);
        cur_id[i]  = id;
        cur_amt[i] = amt;
        req_client_id[i*IW +: IW] = id;
        req_amount[i*DW +: DW]    = amt;
    endtask

    // Predicts winner and the resulting total, then commits it to the model.
    task automatic expect_grant(input logic [N-1:0] m);
        int w;
        logic [DW-1:0] old;
        w = rr_winner(m);
        e_rdy = '0;
        if (w < 0) return;
        e_rdy[w] = 1'b1;
        e_id = cur_id[w];
        old  = ref_mem[e_id];
        if (old > 32'hFFFF_FFFF - cur_amt[w]) begin
            e_tot = 32'hFFFF_FFFF;
            e_sat = 1'b1;
        end else begin
            e_tot = old + cur_amt[w];
            e_sat = 1'b0;
        end
        ref_mem[e_id] = e_tot;
        last_grant = w;
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge of T+4.
    task automatic issue(input logic [N-1:0] m);
        t_ucyc = -1; t_wcnt = 0; t_uid = '0; t_utot = '0; t_usat = 1'b0;
        t_waddr = '0; t_wdata = '0;
        req_valid = m;
        #1 t_rdy = req_ready;
        @(posedge clk);
        #1 req_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (upd_valid) begin
                t_ucyc = c; t_uid = upd_client_id; t_utot = upd_total; t_usat = upd_saturated;
            end
            if (ram_write_enable) begin
                t_wcnt++; t_waddr = ram_addr; t_wdata = ram_write_data;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ram_clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        req_valid = '0; req_client_id = '0; req_amount = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        for (int i = 0; i < N; i++) begin cur_id[i] = '0; cur_amt[i] = '0; end
        last_grant = N - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({req_ready, ram_write_enable, upd_valid, upd_saturated, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy=%b we=%b uv=%b sat=%b busy=%b want all 0",
                     req_ready, ram_write_enable, upd_valid, upd_saturated, busy);
        end
        n_vec++;
        if ({ram_addr, ram_write_data, upd_client_id, upd_total} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h wd=%h uid=%h tot=%h want 0",
                     ram_addr, ram_write_data, upd_client_id, upd_total);
        end
        rst = 1'b0; ram_clr = 1'b0;
    endtask

    task automatic test_single();
        set_req(0, 5'h01, 32'h1);
        expect_grant(4'b0001);
        issue(4'b0001);
        n_vec++;
        if (t_rdy !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", t_rdy); end
        n_vec++;
        if (t_ucyc != 3 || t_wcnt != 1) begin
            n_err++; $display("FAIL single_timing: got upd@T+%0d writes=%0d want T+3 1", t_ucyc, t_wcnt);
        end
        n_vec++;
        if ({t_uid, t_utot, t_usat} !== {5'h01, 32'h1, 1'b0}) begin
            n_err++; $display("FAIL single_upd: got id=%h tot=%h sat=%b want 01 00000001 0", t_uid, t_utot, t_usat);
        end
        n_vec++;
        if ({t_waddr, t_wdata} !== {e_id, e_tot}) begin
            n_err++; $display("FAIL single_write: got %h/%h want %h/%h", t_waddr, t_wdata, e_id, e_tot);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] amts [2];
        logic [DW-1:0] lit  [2];
        amts[0] = 32'hC5;  amts[1] = 32'h5C5;
        lit[0]  = 32'hC5;  lit[1]  = 32'h68A;
        for (int k = 0; k < 2; k++) begin
            set_req(1, 5'h1B, amts[k]);
            expect_grant(4'b0010);
            issue(4'b0010);
            n_vec++;
            if (t_rdy !== e_rdy) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, t_rdy, e_rdy); end
            n_vec++;
            if (t_ucyc != 3 || t_wcnt != 1) begin
                n_err++; $display("FAIL b2b_timing[%0d]: got upd@T+%0d writes=%0d want T+3 1", k, t_ucyc, t_wcnt);
            end
            n_vec++;
            if ({t_uid, t_utot, t_usat} !== {5'h1B, lit[k], 1'b0} || e_tot !== lit[k]) begin
                n_err++; $display("FAIL b2b_total[%0d]: got id=%h tot=%h sat=%b want 1b %h 0", k, t_uid, t_utot, t_usat, lit[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [IW-1:0] q_id[$];
        logic [DW-1:0] q_tot[$];
        logic [IW-1:0] pid;
        logic [DW-1:0] ptot;
        int prev = -1;
        int gcount = 0;
        for (int i = 0; i < N; i++) set_req(i, IW'(8 + i), DW'($urandom_range(1, 4095)));
        req_valid = '1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (req_ready !== '0) begin
                expect_grant('1);
                q_id.push_back(e_id); q_tot.push_back(e_tot);
                n_vec++;
                if (req_ready !== e_rdy) begin n_err++; $display("FAIL rr_order: cycle %0d got %b want %b", cyc, req_ready, e_rdy); end
                if (prev >= 0) begin
                    n_vec++;
                    if (cyc - prev != 4) begin n_err++; $display("FAIL rr_spacing: got %0d cycles want 4", cyc - prev); end
                end
                prev = cyc;
                gcount++;
            end
            if (upd_valid) begin
                pid = '0; ptot = '0;
                if (q_id.size() > 0) begin pid = q_id.pop_front(); ptot = q_tot.pop_front(); end
                n_vec++;
                if ({upd_client_id, upd_total} !== {pid, ptot}) begin
                    n_err++; $display("FAIL rr_update: got %h/%h want %h/%h", upd_client_id, upd_total, pid, ptot);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        n_vec++;
        if (gcount != 5 || q_id.size() != 0) begin
            n_err++; $display("FAIL rr_count: got %0d grants %0d pending want 5 0", gcount, q_id.size());
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] amts [2];
        amts[0] = 32'h20; amts[1] = 32'h1;
        pre_en = 1'b1; pre_addr = 5'h02; pre_data = 32'hFFFF_FFF0;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[2] = 32'hFFFF_FFF0;
        for (int k = 0; k < 2; k++) begin
            set_req(3, 5'h02, amts[k]);
            expect_grant(4'b1000);
            issue(4'b1000);
            n_vec++;
            if ({t_uid, t_utot, t_usat} !== {5'h02, 32'hFFFF_FFFF, 1'b1} || {e_tot, e_sat} !== {32'hFFFF_FFFF, 1'b1}) begin
                n_err++; $display("FAIL sat_total[%0d]: got id=%h tot=%h sat=%b want 02 ffffffff 1", k, t_uid, t_utot, t_usat);
            end
            n_vec++;
            if ({t_waddr, t_wdata} !== {5'h02, 32'hFFFF_FFFF} || t_wcnt != 1) begin
                n_err++; $display("FAIL sat_write[%0d]: got %h/%h x%0d want 02/ffffffff x1", k, t_waddr, t_wdata, t_wcnt);
            end
        end
    endtask

    task automatic test_idle_zero();
        int bad = 0;
        req_valid = '0;
        repeat (8) begin
            @(negedge clk);
            if (busy || ram_write_enable || upd_valid || req_ready !== '0) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
        set_req(1, 5'h04, 32'h0);
        expect_grant(4'b0010);
        issue(4'b0010);
        n_vec++;
        if (t_ucyc != 3 || {t_uid, t_utot, t_usat} !== {5'h04, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL zero_amount: got upd@T+%0d id=%h tot=%h sat=%b want T+3 04 0 0", t_ucyc, t_uid, t_utot, t_usat);
        end
    endtask

    task automatic test_reset_mid();
        int we_seen = 0;
        set_req(2, 5'h03, 32'h10);
        req_valid = 4'b0100;
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, ram_write_enable, upd_valid, ram_addr} !== '0) begin
            n_err++; $display("FAIL midrst_async: got busy=%b we=%b uv=%b addr=%h want 0", busy, ram_write_enable, upd_valid, ram_addr);
        end
        repeat (2) begin @(negedge clk); if (ram_write_enable) we_seen++; end
        rst = 1'b0;
        last_grant = N - 1;
        repeat (4) begin @(negedge clk); if (ram_write_enable) we_seen++; end
        n_vec++;
        if (we_seen != 0 || ram[3] !== ref_mem[3] || ram[3] !== 32'h0) begin
            n_err++; $display("FAIL midrst_drop: got writes=%0d ram[03]=%h want 0 0", we_seen, ram[3]);
        end
        set_req(0, 5'h03, 32'h10);
        for (int i = 1; i < N; i++) set_req(i, IW'(i + 16), DW'($urandom_range(0, 255)));
        expect_grant('1);
        issue('1);
        n_vec++;
        if (t_rdy !== 4'b0001 || e_rdy !== 4'b0001) begin n_err++; $display("FAIL midrst_first: got %b want 0001", t_rdy); end
        n_vec++;
        if ({t_uid, t_utot} !== {5'h03, 32'h10}) begin
            n_err++; $display("FAIL midrst_update: got %h/%h want 03/00000010", t_uid, t_utot);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, IW'($urandom_range(0, 7)),
                        ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 255)));
            end
            m = N'($urandom_range(1, (1 << N) - 1));
            expect_grant(m);
            issue(m);
            n_vec++;
            if (t_rdy !== e_rdy) begin n_err++; $display("FAIL rand_ready[%0d]: mask %b got %b want %b", t, m, t_rdy, e_rdy); end
            n_vec++;
            if (t_ucyc != 3 || t_wcnt != 1 || {t_uid, t_utot, t_usat} !== {e_id, e_tot, e_sat}) begin
                n_err++; $display("FAIL rand_update[%0d]: got T+%0d x%0d %h/%h/%b want T+3 x1 %h/%h/%b",
                                  t, t_ucyc, t_wcnt, t_uid, t_utot, t_usat, e_id, e_tot, e_sat);
            end
            n_vec++;
            if ({t_waddr, t_wdata} !== {e_id, e_tot}) begin
                n_err++; $display("FAIL rand_write[%0d]: got %h/%h want %h/%h", t, t_waddr, t_wdata, e_id, e_tot);
            end
        end
    endtask

    task automatic test_ram_contents();
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (ram[i] !== ref_mem[i]) begin
                n_err++; $display("FAIL ram_contents[%0d]: got %h want %h", i, ram[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_saturation();
        test_idle_zero();
        test_reset_mid();
        test_random();
        test_ram_contents();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
